// File: rtl/cmac_reg_op_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cmac_reg_op_ctrl_pkg
//   Shared constants and types for the CMAC ping-pong register control block.
//   - GROUP_NUM   : number of register groups (G0 / G1)
//   - DONE_CNT_W  : width of the completed-layer counter
//   - group_idx_t : index type selecting one register group
//   - group_onehot: converts a group index to a one-hot group vector
// ---------------------------------------------------------------------------
package cmac_reg_op_ctrl_pkg;

  localparam int GROUP_NUM  = 2;
  localparam int DONE_CNT_W = 8;

  typedef logic group_idx_t;

  // One-hot vector with only the bit of the given group set.
  function automatic logic [GROUP_NUM-1:0] group_onehot(input group_idx_t g);
    logic [GROUP_NUM-1:0] v;
    v    = '0;
    v[g] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/cmac_reg_group.sv
// ---------------------------------------------------------------------------
// cmac_reg_group
//   One register group: holds op_en and conv_mode. Once op_en is set the
//   group is locked and every write is ignored until the datapath reports
//   the layer done (done_clr).
//
//   Ports
//     clk          in  : core clock
//     rst_n        in  : asynchronous active-low reset
//     wr_en        in  : write strobe already decoded for this group
//     wr_op_en     in  : op_en value being written
//     wr_conv_mode in  : conv_mode value being written
//     done_clr     in  : layer of this group finished, release the lock
//     op_en        out : flopped op_en
//     conv_mode    out : flopped conv_mode
// ---------------------------------------------------------------------------
module cmac_reg_group (
  input  logic clk,
  input  logic rst_n,
  input  logic wr_en,
  input  logic wr_op_en,
  input  logic wr_conv_mode,
  input  logic done_clr,
  output logic op_en,
  output logic conv_mode
);

  // Writes are only accepted while the group is idle. done_clr is only ever
  // asserted when op_en is already 1, so it can never collide with an
  // accepted write and its priority here is irrelevant to behaviour.
  logic wr_accept;
  assign wr_accept = wr_en & ~op_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_en     <= 1'b0;
      conv_mode <= 1'b0;
    end else begin
      if (done_clr) begin
        op_en <= 1'b0;
      end else if (wr_accept) begin
        op_en <= wr_op_en;
      end
      if (wr_accept) begin
        conv_mode <= wr_conv_mode;
      end
    end
  end

endmodule

// File: rtl/cmac_reg_op_ctrl.sv
// ---------------------------------------------------------------------------
// cmac_reg_op_ctrl
//   Ping-pong register control for CMAC. Two register groups are programmed
//   by software; the datapath consumes the group selected by the consumer
//   pointer. A done pulse on an armed consumer releases that group, flips
//   the pointer, raises a one-cycle interrupt and counts the layer. A done
//   pulse with nothing armed is flagged as a sticky error.
//
//   Ports
//     nvdla_core_clk     in  : core clock
//     nvdla_core_rstn    in  : asynchronous active-low reset
//     reg_wr_en          in  : one-cycle register write strobe
//     reg_wr_group       in  : target group of the write
//     reg_wr_op_en       in  : op_en value being written
//     reg_wr_conv_mode   in  : conv_mode value being written
//     dp2reg_done        in  : one-cycle layer-done pulse
//     err_clr            in  : clears the sticky error flag
//     reg2dp_op_en       out : op_en of the consumer group
//     reg2dp_conv_mode   out : conv_mode of the consumer group
//     dp2reg_consumer    out : consumer group pointer
//     group_op_en        out : op_en status {G1, G0}
//     intr_done          out : one-cycle done interrupt per group
//     done_count         out : completed-layer count (wraps)
//     err_spurious_done  out : sticky, done seen with no armed group
// ---------------------------------------------------------------------------
module cmac_reg_op_ctrl
  import cmac_reg_op_ctrl_pkg::*;
(
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rstn,
  input  logic                  reg_wr_en,
  input  logic                  reg_wr_group,
  input  logic                  reg_wr_op_en,
  input  logic                  reg_wr_conv_mode,
  input  logic                  dp2reg_done,
  input  logic                  err_clr,
  output logic                  reg2dp_op_en,
  output logic                  reg2dp_conv_mode,
  output logic                  dp2reg_consumer,
  output logic [GROUP_NUM-1:0]  group_op_en,
  output logic [GROUP_NUM-1:0]  intr_done,
  output logic [DONE_CNT_W-1:0] done_count,
  output logic                  err_spurious_done
);

  group_idx_t           consumer;
  logic [GROUP_NUM-1:0] op_en;
  logic [GROUP_NUM-1:0] conv_mode;
  logic [GROUP_NUM-1:0] wr_sel;
  logic [GROUP_NUM-1:0] done_clr;
  logic                 done_fire;
  logic                 done_spurious;

  // A done only counts when the group the datapath was using is armed.
  assign done_fire     = dp2reg_done &  op_en[consumer];
  assign done_spurious = dp2reg_done & ~op_en[consumer];

  assign wr_sel   = reg_wr_en ? group_onehot(reg_wr_group) : '0;
  assign done_clr = done_fire ? group_onehot(consumer) : '0;

  cmac_reg_group u_group0 (
    .clk          (nvdla_core_clk),
    .rst_n        (nvdla_core_rstn),
    .wr_en        (wr_sel[0]),
    .wr_op_en     (reg_wr_op_en),
    .wr_conv_mode (reg_wr_conv_mode),
    .done_clr     (done_clr[0]),
    .op_en        (op_en[0]),
    .conv_mode    (conv_mode[0])
  );

  cmac_reg_group u_group1 (
    .clk          (nvdla_core_clk),
    .rst_n        (nvdla_core_rstn),
    .wr_en        (wr_sel[1]),
    .wr_op_en     (reg_wr_op_en),
    .wr_conv_mode (reg_wr_conv_mode),
    .done_clr     (done_clr[1]),
    .op_en        (op_en[1]),
    .conv_mode    (conv_mode[1])
  );

  // Datapath view is a plain mux of the consumer group's flops, so an arm
  // of the other group landing on the same edge as done gives a gapless
  // back-to-back launch.
  assign reg2dp_op_en     = op_en[consumer];
  assign reg2dp_conv_mode = conv_mode[consumer];
  assign dp2reg_consumer  = consumer;
  assign group_op_en      = op_en;

  // Consumer pointer, interrupt and layer counter all advance on an
  // accepted done. The interrupt is one-hot by construction.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      consumer   <= 1'b0;
      intr_done  <= '0;
      done_count <= '0;
    end else begin
      intr_done <= done_clr;
      if (done_fire) begin
        consumer   <= ~consumer;
        done_count <= done_count + DONE_CNT_W'(1);
      end
    end
  end

  // Sticky error: a spurious done wins over a simultaneous clear.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      err_spurious_done <= 1'b0;
    end else if (done_spurious) begin
      err_spurious_done <= 1'b1;
    end else if (err_clr) begin
      err_spurious_done <= 1'b0;
    end
  end

endmodule
